// File: rtl/keypad_pkg.sv
// Shared types for the matrix keypad scanner: scan FSM states, the key event
// record carried through the event queue, and the key-index mapping.
package keypad_pkg;

   localparam int KEY_CODE_W = 8;

   typedef enum logic [1:0] {
      DRIVE  = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      WAIT   = 2'd3
   } scan_state_t;

   typedef struct packed {
      logic [KEY_CODE_W-1:0] code;
      logic                  press;
   } key_event_t;

   localparam int KEY_EVENT_W = $bits(key_event_t);

   // Keys are numbered column-major: all rows of column 0 first.
   function automatic int key_index(input int col_idx, input int row_idx, input int rows);
      return col_idx * rows + row_idx;
   endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Event queue for the keypad scanner. Registered head, simultaneous push/pop
// allowed even when full; a push into a full queue without a pop is dropped
// and latches the sticky overflow flag. DEPTH must be a power of two >= 2.
module keypad_event_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             overflow_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             full;
   logic             do_pop;
   logic             do_push;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && (cnt_q != '0);
   assign do_push = push_i && (!full || do_pop);

   assign valid_o    = (cnt_q != '0);
   assign data_o     = mem_q[rd_q];
   assign overflow_o = ovf_q;

   // Pointer, occupancy and overflow next-state.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
      if (push_i && full && !do_pop) ovf_d = 1'b1;
   end

   // Queue storage and control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         if (do_push) mem_q[wr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/matrix_keypad_scan.sv
// Matrix keypad scanner: drives one column low per slot, samples each row in
// turn, debounces every key over whole scans and queues press/release events.
// Optional build macro: KEYPAD_GHOST_REJECT_EN -- once two keys are held,
// further presses are held off (likely ghost keys); releases still pass.
//
// state  | meaning
// DRIVE  | slot cycle 0: register one-cold drive for column c
// SETTLE | let the column line settle before sampling
// SAMPLE | one row per cycle, debounce the key at (c, r)
// WAIT   | idle until the last cycle of the slot, then advance c
module matrix_keypad_scan
   import keypad_pkg::*;
#(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_CYCLES    = 100000,
   parameter int SETTLE_CYCLES  = 8,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [ROWS-1:0]                 row,
   output logic [COLS-1:0]                 col,
   output logic                            ev_valid,
   input  logic                            ev_ready,
   output logic [$clog2(ROWS*COLS)-1:0]    ev_code,
   output logic                            ev_press,
   output logic [ROWS*COLS-1:0]            key_state,
   output logic                            overflow
);

   localparam int KEYS   = ROWS * COLS;
   localparam int CODE_W = $clog2(KEYS);
   localparam int SLOT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int C_W    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int R_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DB_W   = $clog2(DEBOUNCE_SCANS + 1);

   scan_state_t       state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [C_W-1:0]    c_q, c_d;
   logic [R_W-1:0]    r_q, r_d;
   logic [COLS-1:0]   col_q, col_d;
   logic              sample_en;

   logic [KEYS-1:0]   key_q, key_d;
   logic [DB_W-1:0]   cnt_q [KEYS];
   logic [DB_W-1:0]   cnt_d [KEYS];
   logic              raw;
   logic              ghost_block;
   logic              push;
   key_event_t        push_ev;
   key_event_t        head_ev;

   // Scan sequencing: slot counter, column/row indices and column drive.
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q + SLOT_W'(1);
      c_d       = c_q;
      r_d       = r_q;
      col_d     = col_q;
      sample_en = 1'b0;
      case (state_q)
         DRIVE: begin
            col_d   = ~(COLS'(1) << c_q);
            state_d = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            r_d     = '0;
         end
         SETTLE: begin
            if (slot_q == SLOT_W'(SETTLE_CYCLES)) begin
               state_d = SAMPLE;
               r_d     = '0;
            end
         end
         SAMPLE: begin
            sample_en = 1'b1;
            if (r_q == R_W'(ROWS - 1)) state_d = WAIT;
            else                       r_d     = r_q + R_W'(1);
         end
         WAIT: begin
            if (slot_q == SLOT_W'(SCAN_CYCLES - 1)) begin
               state_d = DRIVE;
               slot_d  = '0;
               c_d     = (c_q == C_W'(COLS - 1)) ? '0 : c_q + C_W'(1);
            end
         end
         default: state_d = DRIVE;
      endcase
   end

   // Scan FSM registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DRIVE;
         slot_q  <= '0;
         c_q     <= '0;
         r_q     <= '0;
         col_q   <= '1;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         c_q     <= c_d;
         r_q     <= r_d;
         col_q   <= col_d;
      end
   end

   assign raw = ~row[r_q];

`ifdef KEYPAD_GHOST_REJECT_EN
   assign ghost_block = ($countones(key_q) >= 2);
`else
   assign ghost_block = 1'b0;
`endif

   // Per-key debounce of the key currently under the sampler.
   always_comb begin
      key_d   = key_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      push_ev = '0;
      for (int k = 0; k < KEYS; k++) begin
         if (sample_en && (k == key_index(int'(c_q), int'(r_q), ROWS))) begin
            if (raw == key_q[k]) begin
               cnt_d[k] = '0;
            end else if (cnt_q[k] == DB_W'(DEBOUNCE_SCANS - 1)) begin
               if (raw && ghost_block) begin
                  // Hold the press pending so it lands once the extra keys clear.
                  cnt_d[k] = DB_W'(DEBOUNCE_SCANS - 1);
               end else begin
                  key_d[k]      = raw;
                  cnt_d[k]      = '0;
                  push          = 1'b1;
                  push_ev.code  = KEY_CODE_W'(k);
                  push_ev.press = raw;
               end
            end else begin
               cnt_d[k] = cnt_q[k] + DB_W'(1);
            end
         end
      end
   end

   // Debounced key state and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_q <= '0;
         for (int k = 0; k < KEYS; k++) cnt_q[k] <= '0;
      end else begin
         key_q <= key_d;
         for (int k = 0; k < KEYS; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   keypad_event_fifo #(
      .WIDTH (KEY_EVENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_ev),
      .pop_i       (ev_ready),
      .valid_o     (ev_valid),
      .data_o      (head_ev),
      .overflow_o  (overflow)
   );

   generate
      if (CODE_W < KEY_CODE_W) begin : g_code_trim
         logic code_hi_unused;
         assign code_hi_unused = |head_ev.code[KEY_CODE_W-1:CODE_W];
      end
   endgenerate

   assign ev_code   = head_ev.code[CODE_W-1:0];
   assign ev_press  = head_ev.press;
   assign key_state = key_q;
   assign col       = col_q;

endmodule

// File: tb/tb_matrix_keypad_scan.sv
// Bench for matrix_keypad_scan: a keypad model drives the rows from the column
// drive and a held-key map; expected events go into a queue as stimulus is
// applied and are matched against events popped from the DUT.
module tb_matrix_keypad_scan;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int SCAN  = 32;
   localparam int SCANF = SCAN * COLS;

   logic            clk = 1'b0;
   logic            rst;
   logic [ROWS-1:0] row;
   logic [COLS-1:0] col;
   logic            ev_valid;
   logic            ev_ready;
   logic [3:0]      ev_code;
   logic            ev_press;
   logic [15:0]     key_state;
   logic            overflow;

   logic [15:0]     keys;
   logic [4:0]      exp_q [$];
   int              checks = 0;
   int              errors = 0;

   always #5 clk = ~clk;

   matrix_keypad_scan #(
      .ROWS           (ROWS),
      .COLS           (COLS),
      .SCAN_CYCLES    (SCAN),
      .SETTLE_CYCLES  (4),
      .DEBOUNCE_SCANS (2),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_code   (ev_code),
      .ev_press  (ev_press),
      .key_state (key_state),
      .overflow  (overflow)
   );

   // Keypad: a held key pulls its row low while its column is driven low.
   always_comb begin
      row = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (!col[c] && keys[c*ROWS + r]) row[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sync_col(input logic [COLS-1:0] target, input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 2*SCANF && !found; i++) begin
         step(1);
         if (col == target) found = 1'b1;
      end
      check(tag, {31'd0, found}, 32'd1);
   endtask

   // Scoreboard: every accepted DUT event must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && ev_valid && ev_ready) begin
         if (exp_q.size() == 0) check("unexpected_event", {27'd0, ev_code, ev_press}, 32'h100);
         else                   check("event", {27'd0, ev_code, ev_press}, {27'd0, exp_q.pop_front()});
      end
   end

   initial begin
      rst      = 1'b1;
      ev_ready = 1'b0;
      keys     = '0;
      step(3);
      check("reset_col", col, 4'hF);
      check("reset_ev_valid", ev_valid, 0);
      check("reset_key_state", key_state, 0);
      check("reset_overflow", overflow, 0);
      rst = 1'b0;

      // Single press and release of key 9 (row 1, column 2).
      ev_ready = 1'b1;
      keys[9]  = 1'b1;
      exp_q.push_back({4'd9, 1'b1});
      step(3*SCANF);
      check("press9_state", key_state, 16'h0200);
      check("press9_drained", exp_q.size(), 0);

      keys[9] = 1'b0;
      exp_q.push_back({4'd9, 1'b0});
      step(3*SCANF);
      check("release9_state", key_state, 16'h0000);
      check("release9_drained", exp_q.size(), 0);

      // One-scan glitch on key 5.
      keys[5] = 1'b1;
      step(SCANF);
      keys[5] = 1'b0;
      step(3*SCANF);
      check("glitch_state", key_state, 16'h0000);
      check("glitch_no_event", exp_q.size(), 0);

      // Six presses into a four-deep queue with the consumer stalled.
      ev_ready = 1'b0;
      sync_col(4'b0111, "sync_c3_a");
      keys = 16'h003F;
      for (int k = 0; k < 4; k++) exp_q.push_back({4'(k), 1'b1});
      step(3*SCANF);
      check("ovf_set", overflow, 1);
      check("ovf_state", key_state, 16'h003F);
      check("ovf_head_valid", ev_valid, 1);
      check("ovf_head", {ev_code, ev_press}, {4'd0, 1'b1});
      step(7);
      check("ovf_head_hold", {ev_code, ev_press}, {4'd0, 1'b1});
      ev_ready = 1'b1;
      step(10);
      check("ovf_drained", exp_q.size(), 0);
      check("ovf_empty", ev_valid, 0);

      sync_col(4'b0111, "sync_c3_b");
      keys = '0;
      for (int k = 0; k < 6; k++) exp_q.push_back({4'(k), 1'b0});
      step(3*SCANF);
      check("rel6_state", key_state, 16'h0000);
      check("rel6_drained", exp_q.size(), 0);
      check("ovf_sticky", overflow, 1);

      // Reset in the middle of sampling column 2 with an event queued.
      ev_ready = 1'b0;
      sync_col(4'b0111, "sync_c3_c");
      keys[0] = 1'b1;
      step(3*SCANF);
      check("pre_rst_valid", ev_valid, 1);
      sync_col(4'b1011, "sync_c2");
      step(5);
      rst = 1'b1;
      step(1);
      check("midrst_col", col, 4'hF);
      check("midrst_ev_valid", ev_valid, 0);
      check("midrst_overflow", overflow, 0);
      check("midrst_key_state", key_state, 0);
      exp_q.delete();
      rst = 1'b0;
      step(1);
      check("restart_col0", col, 4'b1110);
      ev_ready = 1'b1;
      exp_q.push_back({4'd0, 1'b1});
      step(3*SCANF);
      check("restart_state", key_state, 16'h0001);
      check("restart_drained", exp_q.size(), 0);

      sync_col(4'b0111, "sync_c3_d");
      keys = '0;
      exp_q.push_back({4'd0, 1'b0});
      step(3*SCANF);
      check("rel0_state", key_state, 16'h0000);

      // Three keys on distinct rows and columns: 0, 5, 10.
      sync_col(4'b0111, "sync_c3_e");
      keys = 16'h0421;
      exp_q.push_back({4'd0, 1'b1});
      exp_q.push_back({4'd5, 1'b1});
`ifdef KEYPAD_GHOST_REJECT_EN
      step(3*SCANF);
      check("ghost_state", key_state, 16'h0021);
      step(2*SCANF);
      check("ghost_state_hold", key_state, 16'h0021);
`else
      exp_q.push_back({4'd10, 1'b1});
      step(3*SCANF);
      check("multi_state", key_state, 16'h0421);
`endif
      check("multi_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_keypad_scan.md
MATRIX_KEYPAD_SCAN -- requirements
Module: matrix_keypad_scan

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of row inputs.
REQ-002 SHALL have parameter COLS, default 4: number of column drives.
REQ-003 SHALL have parameter SCAN_CYCLES, default 100000: clk cycles per column slot; legal only when SCAN_CYCLES >= SETTLE_CYCLES+ROWS+2.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 8: cycles between column drive and the first row sample.
REQ-005 SHALL have parameter DEBOUNCE_SCANS, default 3: consecutive full scans with identical raw value needed to change a key's stable state.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: event queue depth, a power of two.
REQ-007 SHALL have port clk, input, 1: clock.
REQ-008 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port row, input, ROWS: row sense lines, active-low.
REQ-010 SHALL have port col, output, COLS: column drives, one-cold while driving.
REQ-011 SHALL have port ev_valid, output, 1: event available at the FIFO head.
REQ-012 SHALL have port ev_ready, input, 1: consumer accepts the head event.
REQ-013 SHALL have port ev_code, output, $clog2(ROWS*COLS): key index of the head event, equal to col_index*ROWS+row_index.
REQ-014 SHALL have port ev_press, output, 1: 1 means press, 0 means release.
REQ-015 SHALL have port key_state, output, ROWS*COLS: debounced stable state, with bit k = key k pressed.
REQ-016 SHALL have port overflow, output, 1: sticky flag meaning an event was dropped.

Function
REQ-017 SHALL run FSM states DRIVE (1 cycle, col <= one-cold on column c), SETTLE (SETTLE_CYCLES cycles), SAMPLE (ROWS cycles, row index r = 0..ROWS-1, one key per cycle) and WAIT (until slot cycle SCAN_CYCLES-1), then advance c.
REQ-018 SHALL make each column slot exactly SCAN_CYCLES cycles long, and c SHALL wrap from COLS-1 to 0.
REQ-019 SHALL treat raw pressed as row[r]==0 during the SAMPLE cycle for r.
REQ-020 SHALL give each key a debounce counter that is cleared when raw equals stable and incremented when they differ; when it reaches DEBOUNCE_SCANS the stable bit SHALL toggle, the counter SHALL clear, and an event {code,press} SHALL be pushed in the same cycle.
REQ-021 SHALL push at most one event per cycle, in column-major then ascending row order.
REQ-022 SHALL present a pushed event on ev_valid/ev_code/ev_press on the next cycle if the FIFO was empty.
REQ-023 SHALL pop the head on a cycle where ev_valid&&ev_ready; ev_code/ev_press SHALL hold steady while ev_valid&&!ev_ready.
REQ-024 SHALL drop a push attempted while the FIFO is full with no pop, and SHALL set overflow, which stays 1 until rst.
REQ-025 SHALL accept both operations when push and pop occur in the same cycle while full, leaving occupancy unchanged.
REQ-026 SHALL update key_state in the cycle the stable bit toggles.

Reset
REQ-027 SHALL, on rst, drive col to all ones, clear key_state, all debounce counters, the FIFO, ev_valid and overflow, and set the FSM to DRIVE with c=0 and slot counter 0.
REQ-028 SHALL, on rst asserted mid-slot, abort the scan; the first cycle after deassertion SHALL be DRIVE of column 0, and no partial events SHALL remain.

Configuration
REQ-029 SHALL, when KEYPAD_GHOST_REJECT_EN is defined and key_state already has >= 2 keys pressed, not toggle a pending press; its counter SHALL hold at DEBOUNCE_SCANS-1 and no event SHALL be pushed, while releases proceed normally.
REQ-030 SHALL, when KEYPAD_GHOST_REJECT_EN is undefined, process every key independently with no press suppression.

Structure
REQ-031 SHALL take the FSM state enum, the event struct typedef {code,press} and the key-index function from shared package keypad_pkg.
REQ-032 SHALL implement the event queue as sub-module keypad_event_fifo, parameterised by width and FIFO_DEPTH.

Verification (bench parameters ROWS=4, COLS=4, SCAN_CYCLES=32, SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4)
REQ-033 SHALL test: hold key r1,c2 pressed for 3 scans -> exactly one event code=9, press=1, and key_state[9]=1.
REQ-034 SHALL test: release key 9 -> one event code=9, press=0, and key_state=0.
REQ-035 SHALL test: a 1-scan glitch on key 5 -> no event, and key_state unchanged.
REQ-036 SHALL test: press keys 0,1,2,3,4,5 simultaneously with ev_ready=0 -> 4 events queued with codes 0,1,2,3 and overflow=1.
REQ-037 SHALL test: rst asserted during SAMPLE of column 2 -> col=4'b1111, ev_valid=0 and overflow=0 next cycle, and the scan restarts at column 0.
REQ-038 SHALL test with KEYPAD_GHOST_REJECT_EN: press keys 0,5,10 -> events for 0 and 5 only, and key_state=16'h0021.
